// File: rtl/adc_sample_buffer.sv
// ADC sample buffer: averages 2^win_log2 ADC codes per window and queues each
// window result in a small register FIFO for a valid/ready consumer.
module adc_sample_buffer #(
    parameter int DATA_W       = 9,
    parameter int MAX_AVG_LOG2 = 4,
    parameter int DEPTH        = 16
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              enable,
    input  logic [$clog2(MAX_AVG_LOG2+1)-1:0] avg_sel,
    input  logic                              adc_valid,
    input  logic [DATA_W-1:0]                 adc_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_W-1:0]                 out_data,
    output logic [$clog2(DEPTH):0]            fill,
    output logic                              overflow,
    input  logic                              clr_ovf,
    output logic                              state_dbg
);

    localparam int SEL_W  = $clog2(MAX_AVG_LOG2 + 1);
    localparam int ACC_W  = DATA_W + MAX_AVG_LOG2;
    localparam int CNT_W  = MAX_AVG_LOG2 + 1;
    localparam int AW     = $clog2(DEPTH);
    localparam int FILL_W = AW + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [SEL_W-1:0]   win_log2, win_nxt;
    logic [SEL_W-1:0]   sel_clamped;
    logic [CNT_W-1:0]   win_last;
    logic [ACC_W-1:0]   sum;
    logic               push_req;
    logic [DATA_W-1:0]  push_data;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               full;
    logic               pop;
    logic               push_ok;
    logic               drop;

    assign state_dbg = (state == ACCUM);

    always_comb begin
        sel_clamped = avg_sel;
        if (avg_sel > SEL_W'(MAX_AVG_LOG2)) begin
            sel_clamped = SEL_W'(MAX_AVG_LOG2);
        end
    end

    // The final sample of a window is folded into the sum directly, so the
    // accumulator only ever holds up to 2^win_log2 - 1 samples and cannot wrap.
    assign win_last  = (CNT_W'(1) << win_log2) - CNT_W'(1);
    assign sum       = acc + ACC_W'(adc_data);
    assign push_data = DATA_W'(sum >> win_log2);

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        win_nxt   = win_log2;
        push_req  = 1'b0;
        case (state)
            IDLE: begin
                acc_nxt = '0;
                cnt_nxt = '0;
                if (enable) begin
                    state_nxt = ACCUM;
                    win_nxt   = sel_clamped;
                end
            end
            ACCUM: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (adc_valid) begin
                    if (cnt == win_last) begin
                        push_req = 1'b1;
                        acc_nxt  = '0;
                        cnt_nxt  = '0;
                        win_nxt  = sel_clamped;
                    end else begin
                        acc_nxt = sum;
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                acc_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            win_log2 <= '0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            cnt      <= cnt_nxt;
            win_log2 <= win_nxt;
        end
    end

    // Handshake: a word transfers on every rising edge where out_valid and
    // out_ready are both 1; out_data holds steady while out_valid=1 and
    // out_ready=0, and reads as zero whenever out_valid=0.
    assign out_valid = (fill != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign full      = (fill == FILL_W'(DEPTH));
    assign pop       = out_valid && out_ready;
    assign push_ok   = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   fill <= fill + FILL_W'(1);
                2'b01:   fill <= fill - FILL_W'(1);
                default: fill <= fill;
            endcase
        end
    end

    // A drop in the same cycle as clr_ovf wins so no loss goes unreported.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_sample_buffer.sv
// Directed bench for adc_sample_buffer: pass-through, averaging, clamp, abort,
// overflow, pointer wrap and asynchronous reset.
module tb_adc_sample_buffer;

    localparam int DATA_W = 9;
    localparam int DEPTH  = 16;

    logic              clock;
    logic              reset_n;
    logic              enable;
    logic [2:0]        avg_sel;
    logic              adc_valid;
    logic [DATA_W-1:0] adc_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [4:0]        fill;
    logic              overflow;
    logic              clr_ovf;
    logic              state_dbg;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    adc_sample_buffer #(.DATA_W(DATA_W), .MAX_AVG_LOG2(4), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .avg_sel   (avg_sel),
        .adc_valid (adc_valid),
        .adc_data  (adc_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .fill      (fill),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // drivers: every input change lands 1 time unit after a rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [DATA_W-1:0] d);
        adc_valid = 1'b1;
        adc_data  = d;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic start_window(input logic [2:0] sel);
        enable = 1'b0;
        tick();
        enable  = 1'b1;
        avg_sel = sel;
        tick();
    endtask

    initial begin
        int pushed;
        int cyc;
        logic [DATA_W-1:0] d;

        reset_n   = 1'b0;
        enable    = 1'b0;
        avg_sel   = 3'd0;
        adc_valid = 1'b0;
        adc_data  = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        #22;
        check("rst_fill", fill, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ovf", overflow, 0);
        check("rst_state", state_dbg, 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("idle_state", state_dbg, 0);

        // pass-through
        out_ready = 1'b1;
        start_window(3'd0);
        check("pt_state", state_dbg, 1);
        strobe(9'h000);
        check("pt0_valid", out_valid, 1);
        check("pt0_data", out_data, 9'h000);
        check("pt0_fill", fill, 1);
        strobe(9'h1FF);
        check("pt1_data", out_data, 9'h1FF);
        check("pt1_fill", fill, 1);
        strobe(9'h0A5);
        check("pt2_data", out_data, 9'h0A5);
        check("pt2_fill", fill, 1);
        tick();
        check("pt_empty_valid", out_valid, 0);
        check("pt_empty_data", out_data, 0);
        tick();
        check("pt_ready_empty_fill", fill, 0);

        // averaging 2^2
        start_window(3'd2);
        strobe(9'd10);
        strobe(9'd11);
        strobe(9'd12);
        check("avg2_partial", out_valid, 0);
        strobe(9'd14);
        check("avg2_valid", out_valid, 1);
        check("avg2_data", out_data, 11);

        // averaging 2^4 full scale, with a mid-window avg_sel change
        start_window(3'd4);
        check("avg4_drained", fill, 0);
        for (int i = 0; i < 15; i++) begin
            if (i == 3) avg_sel = 3'd1;
            strobe(9'h1FF);
        end
        check("avg4_partial", fill, 0);
        strobe(9'h1FF);
        check("avg4_fill", fill, 1);
        check("avg4_data", out_data, 9'h1FF);

        // avg_sel above the maximum clamps to 4
        start_window(3'd7);
        for (int i = 0; i < 15; i++) strobe(9'd0);
        check("clamp_partial", fill, 0);
        strobe(9'h1F0);
        check("clamp_data", out_data, 31);
        tick();

        // abort mid-window
        start_window(3'd2);
        strobe(9'd5);
        strobe(9'd6);
        strobe(9'd7);
        enable    = 1'b0;
        adc_valid = 1'b1;
        adc_data  = 9'd100;
        tick();
        check("abort_state", state_dbg, 0);
        tick();
        enable = 1'b1;
        tick();
        adc_valid = 1'b0;
        check("abort_nopush", fill, 0);
        for (int i = 0; i < 3; i++) strobe(9'd8);
        check("abort_partial", fill, 0);
        strobe(9'd8);
        check("abort_data", out_data, 8);
        check("abort_fill", fill, 1);
        tick();

        // overflow with a stalled consumer
        out_ready = 1'b0;
        start_window(3'd0);
        for (int i = 0; i < DEPTH; i++) begin
            d = DATA_W'(i * 29 + 3);
            strobe(d);
            if (i > 0) exp_q.push_back(d);
        end
        check("ovf_full_fill", fill, 16);
        check("ovf_not_yet", overflow, 0);
        strobe(9'h111);
        check("ovf_fill", fill, 16);
        check("ovf_flag", overflow, 1);
        check("ovf_head", out_data, 3);
        clr_ovf = 1'b1;
        strobe(9'h122);
        check("ovf_clr_vs_drop", overflow, 1);
        tick();
        clr_ovf = 1'b0;
        check("ovf_clr", overflow, 0);
        out_ready = 1'b1;
        strobe(9'h133);
        exp_q.push_back(9'h133);
        check("ovf_pushpop_fill", fill, 16);
        check("ovf_pushpop_flag", overflow, 0);
        while (exp_q.size() != 0) begin
            check("ovf_drain", out_data, exp_q.pop_front());
            tick();
        end
        check("ovf_drained", fill, 0);

        // pointer wrap with random back-pressure
        pushed = 0;
        cyc    = 0;
        while (pushed < 40 && cyc < 400) begin
            out_ready = 1'($urandom_range(0, 1));
            if (exp_q.size() < DEPTH - 1 && $urandom_range(0, 1) == 1) begin
                adc_valid = 1'b1;
                adc_data  = DATA_W'($urandom_range(0, 511));
            end else begin
                adc_valid = 1'b0;
            end
            check("wrap_valid", out_valid, exp_q.size() != 0);
            if (out_ready && exp_q.size() != 0) check("wrap_data", out_data, exp_q.pop_front());
            if (adc_valid) begin
                exp_q.push_back(adc_data);
                pushed++;
            end
            tick();
            cyc++;
        end
        adc_valid = 1'b0;
        check("wrap_pushed", pushed, 40);
        check("wrap_fill", fill, exp_q.size());
        out_ready = 1'b1;
        while (exp_q.size() != 0) begin
            check("wrap_drain", out_data, exp_q.pop_front());
            tick();
        end
        check("wrap_empty", fill, 0);
        check("wrap_ovf", overflow, 0);

        // asynchronous reset with data queued and a partial window
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) strobe(DATA_W'(i + 40));
        avg_sel = 3'd2;
        strobe(9'd44);
        strobe(9'd1);
        strobe(9'd2);
        check("rstm_pre_fill", fill, 5);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstm_fill", fill, 0);
        check("rstm_valid", out_valid, 0);
        check("rstm_data", out_data, 0);
        check("rstm_ovf", overflow, 0);
        check("rstm_state", state_dbg, 0);
        #1;
        reset_n = 1'b1;
        enable  = 1'b1;
        avg_sel = 3'd2;
        tick();
        for (int i = 0; i < 3; i++) strobe(9'd20);
        check("rstm_partial", fill, 0);
        strobe(9'd20);
        check("rstm_data_after", out_data, 20);
        check("rstm_fill_after", fill, 1);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
